serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 140 ++++++++++++++
 tb/tb_serial_subtractor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, with borrow/overflow/zero flags.
// Optional zero flag is built only when SERIAL_SUBTRACTOR_ZERO_FLAG_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             over,
    output logic             zero
);

    localparam int CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] d_sh_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             br_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             over_reg;

    logic             ai;
    logic             bi;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] diff_next;
    logic             over_next;
    logic             last_bit;

    // One full-subtractor slice; result bits enter at the MSB so the
    // register holds the aligned difference after WIDTH shifts.
    always_comb begin
        ai        = a_sh_reg[0];
        bi        = b_sh_reg[0];
        d_bit     = ai ^ bi ^ br_reg;
        br_next   = (~ai & bi) | (~(ai ^ bi) & br_reg);
        diff_next = {d_bit, d_sh_reg[WIDTH-1:1]};
        over_next = (a_msb_reg != b_msb_reg) & (diff_next[WIDTH-1] != a_msb_reg);
        last_bit  = (cnt_reg == CNT_W'(WIDTH - 1));
    end

`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    logic zero_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            d_sh_reg   <= '0;
            cnt_reg    <= '0;
            br_reg     <= 1'b0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            over_reg   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
            zero_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        a_msb_reg <= a[WIDTH-1];
                        b_msb_reg <= b[WIDTH-1];
                        d_sh_reg  <= '0;
                        cnt_reg   <= '0;
                        br_reg    <= 1'b0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_reg <= a_sh_reg >> 1;
                    b_sh_reg <= b_sh_reg >> 1;
                    d_sh_reg <= diff_next;
                    br_reg   <= br_next;
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    if (last_bit) begin
                        state_reg  <= DONE;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        diff_reg   <= diff_next;
                        borrow_reg <= br_next;
                        over_reg   <= over_next;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
                        zero_reg   <= (diff_next == '0);
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign diff   = diff_reg;
    assign borrow = borrow_reg;
    assign over   = over_reg;

`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    assign zero = zero_reg;
`else
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: accepted operations push arithmetic expectations,
// a monitor pops them on done and checks every output each cycle.
module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int MOD   = 1 << WIDTH;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             over;
    logic             zero;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .borrow(borrow),
        .over  (over),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int diff;
        int borrow;
        int over;
        int zero;
        int done_edge;
        int a;
        int b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   e = 0;
    int   next_free = 0;
    int   last_k = 0;
    bit   have_run = 1'b0;
    bit   busy_exp = 1'b0;
    int   held_diff = 0, held_borrow = 0, held_over = 0, held_zero = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, e);
        end
    endtask

    // Reference: plain integer arithmetic on the operands present at the accepting edge.
    function automatic exp_t model(input int av, input int bv, input int edge_no);
        exp_t r;
        int sa, sb, sd;
        sa = (av >= MOD / 2) ? av - MOD : av;
        sb = (bv >= MOD / 2) ? bv - MOD : bv;
        sd = sa - sb;
        r.diff      = ((av - bv) % MOD + MOD) % MOD;
        r.borrow    = (av < bv) ? 1 : 0;
        r.over      = (sd < -(MOD / 2) || sd > MOD / 2 - 1) ? 1 : 0;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
        r.zero      = (r.diff == 0) ? 1 : 0;
`else
        r.zero      = 0;
`endif
        r.done_edge = edge_no + WIDTH;
        r.a         = av;
        r.b         = bv;
        return r;
    endfunction

    // Acceptance model: a start is taken when no operation is outstanding or in its result cycle.
    always @(posedge clk) begin
        e = e + 1;
        if (rst_n === 1'b1 && start === 1'b1 && e >= next_free) begin
            q.push_back(model(int'(a), int'(b), e));
            last_k    = e;
            have_run  = 1'b1;
            next_free = e + WIDTH + 1;
            $display("accept edge %0d: a=%b b=%b", e, a, b);
        end
        busy_exp = have_run && (e - last_k) < WIDTH;
    end

    always @(posedge clk) begin
        exp_t it;
        bit   done_exp;
        #1;
        done_exp = (q.size() > 0) && (q[0].done_edge == e);
        check("done", int'(done), int'(done_exp));
        check("busy", int'(busy), int'(busy_exp));
        if (q.size() > 0 && q[0].done_edge <= e) begin
            it = q.pop_front();
            held_diff   = it.diff;
            held_borrow = it.borrow;
            held_over   = it.over;
            held_zero   = it.zero;
            $display("result edge %0d: a=%0d b=%0d diff=%b borrow=%b over=%b zero=%b",
                     e, it.a, it.b, diff, borrow, over, zero);
        end
        check("diff", int'(diff), held_diff);
        check("borrow", int'(borrow), held_borrow);
        check("over", int'(over), held_over);
        check("zero", int'(zero), held_zero);
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        have_run  = 1'b0;
        busy_exp  = 1'b0;
        next_free = 0;
        held_diff = 0; held_borrow = 0; held_over = 0; held_zero = 0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_flags", int'({borrow, over, zero}), 0);
        $display("reset asserted at edge %0d", e);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, q.size(), 0);
    endtask

    task automatic one_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        a = av;
        b = bv;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        wait_drain("op_timeout");
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        #1;
        check("init_busy", int'(busy), 0);
        check("init_diff", int'(diff), 0);
        @(negedge clk);
        rst_n = 1'b1;

        one_op(4'b0101, 4'b0011);
        one_op(4'b0011, 4'b0101);
        one_op(4'b0111, 4'b1000);
        one_op(4'b1000, 4'b0001);
        one_op(4'b0110, 4'b0110);
        one_op(4'b0000, 4'b1111);
        one_op(4'b1111, 4'b1111);

        // start held high with operands changing every cycle
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = 1'b1;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain("cont_timeout");

        // abort two cycles into RUN
        @(negedge clk);
        start = 1'b1;
        a = 4'b1010;
        b = 4'b0101;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        apply_reset();
        one_op(4'b1111, 4'b0001);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            if (i == 150) apply_reset();
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain("final_drain");
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
